// File: rtl/sumador_multibyte_ctrl.sv
// Purpose: multi-byte adder sequencer driving one shared 8-bit adder, LSB byte first, carry chained in a register.
// Latency: start accepted at edge E0, done pulses in the cycle after edge E0+NBYTES; ready again one cycle later.
// Backpressure: start is only accepted while ready=1; starts during RUN/DONE are dropped. Optional: SUMADOR_RESTA_EN adds sub/ovf.

// Existing 8-bit adder block, kept with its original port names.
module sumador8 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [8:0] S
);
  assign S = {1'b0, A} + {1'b0, B} + {8'd0, Cin};
endmodule

module sumador_multibyte_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
`ifdef SUMADOR_RESTA_EN
  input  logic                  sub,
  output logic                  ovf,
`endif
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_reg, b_reg;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic [7:0]      a_byte, b_byte, b_in;
  logic [8:0]      s;
  logic            last;
`ifdef SUMADOR_RESTA_EN
  logic            sub_reg;
  logic            carry_in_msb;
`endif

  // Select the operand byte addressed by the counter; subtraction inverts the B byte.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (cnt == CW'(i)) begin
        a_byte = a_reg[8*i +: 8];
        b_byte = b_reg[8*i +: 8];
      end
    end
`ifdef SUMADOR_RESTA_EN
    b_in = sub_reg ? ~b_byte : b_byte;
`else
    b_in = b_byte;
`endif
  end

  assign last = (cnt == CW'(NBYTES - 1));

`ifdef SUMADOR_RESTA_EN
  // Carry into bit 7 of the current byte, recovered from the sum bit.
  assign carry_in_msb = a_byte[7] ^ b_in[7] ^ s[7];
`endif

  sumador8 u_add (
    .A   (a_byte),
    .B   (b_in),
    .Cin (carry),
    .S   (s)
  );

  // Next-state and handshake outputs decoded from the state.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Operand capture, per-byte result write-back and carry chaining.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      cout    <= 1'b0;
`ifdef SUMADOR_RESTA_EN
      sub_reg <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            cnt   <= '0;
`ifdef SUMADOR_RESTA_EN
            sub_reg <= sub;
            carry   <= sub ? 1'b1 : cin;
`else
            carry   <= cin;
`endif
          end
        end
        S_RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (cnt == CW'(i)) result[8*i +: 8] <= s[7:0];
          end
          carry <= s[8];
          if (last) begin
            cout <= s[8];
`ifdef SUMADOR_RESTA_EN
            ovf  <= carry_in_msb ^ s[8];
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_multibyte_ctrl.sv
// Purpose: self-checking bench for sumador_multibyte_ctrl (NBYTES=4), vector table, corner sequences, random ops.
// Latency: expects done exactly NBYTES edges after the accepting edge, ready one cycle after done.
// Backpressure: exercises starts held high through RUN/DONE; SUMADOR_RESTA_EN enables sub/ovf checks.
module tb_sumador_multibyte_ctrl;

  localparam int N = 4;
  localparam int W = 8 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_i, b_i;
  logic         cin_i;
  logic         sub_i;
  logic         ready, busy, done, cout;
  logic [W-1:0] result;
  logic         ovf_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sumador_multibyte_ctrl #(.NBYTES(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a_i),
    .b      (b_i),
    .cin    (cin_i),
`ifdef SUMADOR_RESTA_EN
    .sub    (sub_i),
    .ovf    (ovf_o),
`endif
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

`ifndef SUMADOR_RESTA_EN
  assign ovf_o = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic; overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W:0]   sum;
    logic [W-1:0] bb;
    logic         c, ov;
    bb  = sub ? ~b : b;
    c   = sub ? 1'b1 : cin;
    sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    ov  = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
    return {ov, sum};
  endfunction

  // Full transaction: accept, wait for done with timing checks, return to IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, output logic [W-1:0] r, output logic co,
                        output logic ov);
    int lat;
    chk("ready_before_start", ready, 1);
    start = 1'b1; a_i = a; b_i = b; cin_i = cin; sub_i = sub;
    tick();
    start = 1'b0;
    a_i = $urandom; b_i = $urandom; cin_i = 1'($urandom); sub_i = 1'($urandom);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", lat, N);
    chk("busy_at_done", busy, 0);
    chk("ready_at_done", ready, 0);
    r = result; co = cout; ov = ovf_o;
    tick();
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", ready, 1);
  endtask

  initial begin
    logic [W-1:0] r, a0, b0, a1, b1, mask;
    logic         co, ov;
    logic [W+1:0] m;
    int           lat, ndone;

    vecs.push_back('{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{32'hDEAD0000, 32'h0000BEEF, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0});
    vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1});
    vecs.push_back('{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0});
`ifdef SUMADOR_RESTA_EN
    vecs.push_back('{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1});
    vecs.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});
    vecs.push_back('{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});
`endif

    rst = 1'b1; start = 1'b1; a_i = '1; b_i = '1; cin_i = 1'b1; sub_i = 1'b0;
    tick(); tick();
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf_o, 0);
    rst = 1'b0; start = 1'b0;
    tick();

    // Vector table.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, r, co, ov);
      chk($sformatf("vec%0d_result", i), r, vecs[i].r);
      chk($sformatf("vec%0d_cout", i), co, vecs[i].co);
`ifdef SUMADOR_RESTA_EN
      chk($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
`endif
    end

    // Hold: result stays DEADBEEF with start low and operands toggling.
    run_op(32'hDEAD0000, 32'h0000BEEF, 1'b0, 1'b0, r, co, ov);
    chk("hold_setup", r, 32'hDEADBEEF);
    for (int k = 0; k < 20; k++) begin
      a_i = $urandom; b_i = $urandom; cin_i = 1'($urandom);
      tick();
      chk("hold_result", result, 32'hDEADBEEF);
      chk("hold_cout", cout, 0);
      chk("hold_done", done, 0);
    end

    // Carry ripple: bytes of the previous result are overwritten one per cycle.
    start = 1'b1; a_i = 32'hFFFFFFFF; b_i = 32'h0; cin_i = 1'b1; sub_i = 1'b0;
    tick();
    start = 1'b0; a_i = $urandom; b_i = $urandom;
    for (int k = 1; k < N; k++) begin
      tick();
      mask = ~((32'h1 << (8 * k)) - 32'h1);
      chk($sformatf("ripple_byte%0d", k), result, 32'hDEADBEEF & mask);
      chk("ripple_busy", busy, 1);
    end
    tick();
    chk("ripple_done", done, 1);
    chk("ripple_result", result, 0);
    chk("ripple_cout", cout, 1);
    tick();

    // Starts held high through RUN/DONE are dropped; next accept only when ready.
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    start = 1'b1; a_i = a0; b_i = b0; cin_i = 1'b0; sub_i = 1'b0;
    tick();
    for (int k = 1; k <= N; k++) begin
      a_i = $urandom; b_i = $urandom; cin_i = 1'($urandom);
      tick();
    end
    m = model(a0, b0, 1'b0, 1'b0);
    chk("ign_done", done, 1);
    chk("ign_result", result, m[W-1:0]);
    chk("ign_cout", cout, m[W]);
    a_i = a1; b_i = b1; cin_i = 1'b0;
    tick();
    chk("ign_ready_after_done", ready, 1);
    tick();
    start = 1'b0; a_i = $urandom; b_i = $urandom;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    m = model(a1, b1, 1'b0, 1'b0);
    chk("b2b_latency", lat, N);
    chk("b2b_result", result, m[W-1:0]);
    tick();

    // Reset in the second RUN cycle discards the operation.
    start = 1'b1; a_i = 32'h12345678; b_i = 32'h1; cin_i = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_cout", cout, 0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) ndone++;
      tick();
    end
    chk("midrst_no_done", ndone, 0);

    // Random operations against the reference model.
    for (int k = 0; k < 150; k++) begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
`ifdef SUMADOR_RESTA_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (k % 10 == 0) ra = '1;
      run_op(ra, rb, rc, rs, r, co, ov);
      m = model(ra, rb, rc, rs);
      chk("rand_result", r, m[W-1:0]);
      chk("rand_cout", co, m[W]);
`ifdef SUMADOR_RESTA_EN
      chk("rand_ovf", ov, m[W+1]);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
